gptp_tx_arbiter: RTL and testbench
==================================

Name: gptp_tx_arbiter

Overview:
- Shares the single gPTP transmit frame path (352-bit frame, valid/ready) between up to N_REQ message sources, such as Sync, Follow_Up, Pdelay_Req and Pdelay_Resp.
- Sources are served round-robin.
- At the egress handshake the block captures the RTC time as an 80-bit egress timestamp and returns it, tagged with the originating source ID.
- Sits between the gPTP message generators and the TX framing/MAC path.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- FRAME_W, 352, frame width in bits.
- TX_TIMEOUT, 1000, maximum cycles in SEND without gptp_ts_ready before the frame is dropped; legal range 2..2^16-1.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous reset, active-high.
- req_vaild  in  N_REQ  per-source frame valid.
- req_ready  out  N_REQ  per-source accept; one-hot or zero.
- req_data  in  N_REQ*FRAME_W  source i frame is at bits [i*FRAME_W +: FRAME_W].
- gptp_ts_vaild  out  1  frame valid toward TX.
- gptp_ts_ready  in  1  TX accepts the frame.
- gptp_ts_data  out  FRAME_W  latched frame.
- rtc_nanosec_field  in  32  RTC nanoseconds.
- rtc_sec_field  in  32  RTC seconds.
- rtc_epoch_field  in  16  RTC epoch.
- ts_ret_vaild  out  1  one-cycle pulse: egress timestamp valid.
- ts_ret_data  out  80  {epoch, sec, nanosec} captured at the egress handshake.
- ts_ret_id  out  3  index of the source the timestamp belongs to.
- tx_timeout  out  1  one-cycle pulse: frame dropped on timeout.
- busy  out  1  high when state is not IDLE.

Behaviour:
- States: IDLE, SEND, RET. The state register is encoded in 2 bits.
- Reset, taking effect on a clk edge with reset=1:
  - state=IDLE; rr_ptr=N_REQ-1, so source 0 has first priority.
  - gptp_ts_data=0, ts_ret_data=0, ts_ret_id=0, timeout counter=0.
  - All outputs low.
  - Reset asserted in SEND or RET aborts the transfer: no ts_ret_vaild pulse and no tx_timeout pulse are produced.
- IDLE:
  - Grant = first asserted req_vaild bit, searching from rr_ptr+1 upward and wrapping modulo N_REQ.
  - req_ready[grant] is asserted combinationally in the same cycle; it is only ever high in IDLE.
  - On that edge:
    - gptp_ts_data <= the granted frame.
    - grant_id <= grant.
    - rr_ptr <= grant.
    - timeout counter <= 0.
    - state <= SEND.
  - With no requests, the block stays in IDLE and rr_ptr is unchanged.
- SEND:
  - gptp_ts_vaild=1 (decoded from the registered state). gptp_ts_data is stable throughout SEND.
  - If gptp_ts_ready:
    - ts_ret_data <= {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field}, sampled in the handshake cycle.
    - ts_ret_id <= grant_id.
    - state <= RET.
  - Else if counter == TX_TIMEOUT-1:
    - tx_timeout pulses 1 cycle, registered, so it is high in the cycle after the edge.
    - state <= IDLE.
  - Else counter increments.
  - If gptp_ts_ready arrives in the same cycle as the timeout limit, ready wins: no timeout, a timestamp is returned.
- RET:
  - ts_ret_vaild=1 for exactly one cycle.
  - ts_ret_data and ts_ret_id are held stable until the next RET.
  - state <= IDLE unconditionally; the return path has no backpressure.
- Latency and throughput:
  - Grant to gptp_ts_vaild: 1 cycle.
  - Egress handshake to ts_ret_vaild: 1 cycle.
  - Minimum 3 cycles per frame.
- Fairness: with all sources continuously requesting, grants rotate 0,1,...,N_REQ-1,0,...
- Request deassertion:
  - A source that deasserts req_vaild before being granted is simply skipped.
  - req_data is only sampled at the grant edge.
- The timeout counter is 16 bits. It never wraps, because it is bounded by TX_TIMEOUT-1.
- busy = (state != IDLE).

Test Plan:
- Single request: req_vaild=0001, frame A, gptp_ts_ready tied 1, RTC={16'h1,32'h5,32'd100} at the handshake.
  - req_ready=0001 for 1 cycle.
  - gptp_ts_vaild for 1 cycle with data A.
  - Next cycle: ts_ret_vaild=1, ts_ret_id=0, ts_ret_data=80'h0001_00000005_00000064.
- All four sources held valid, ready=1, 8 frames sent.
  - Grant order 0,1,2,3,0,1,2,3.
  - Each frame appears on gptp_ts_data with a matching ts_ret_id.
  - Frames spaced 3 cycles apart.
- Backpressure:
  - Source 2 granted, gptp_ts_ready held 0: after exactly TX_TIMEOUT SEND cycles, tx_timeout pulses once, no ts_ret_vaild, block returns to IDLE.
  - Next grant is source 3 (if requesting).
- Boundary on timeout: gptp_ts_ready rises in SEND cycle TX_TIMEOUT (the last SEND cycle) -> no tx_timeout, ts_ret_vaild pulses with the RTC value of that cycle.
- Mid-operation reset:
  - Reset asserted in SEND: next cycle all outputs are 0, no ret or timeout pulse.
  - After release with req_vaild=1111, source 0 is granted first.
- Stalled TX with pending requests: while in SEND with ready=0, toggling req_vaild on other sources -> req_ready stays 0 and gptp_ts_data is unchanged.

Source files
------------

// File: rtl/gptp_tx_arbiter.sv
// gptp_tx_arbiter: round-robin arbiter that shares one gPTP transmit frame
// path between N_REQ message sources. It latches the granted frame, presents
// it to the TX path, and on the egress handshake captures the RTC time. That
// time is returned one cycle later as an egress timestamp tagged with the
// source index. A frame that TX does not accept within TX_TIMEOUT cycles is
// dropped and flagged with a one-cycle tx_timeout pulse.
module gptp_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FRAME_W    = 352,
    parameter int TX_TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_vaild,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*FRAME_W-1:0] req_data,
    output logic                     gptp_ts_vaild,
    input  logic                     gptp_ts_ready,
    output logic [FRAME_W-1:0]       gptp_ts_data,
    input  logic [31:0]              rtc_nanosec_field,
    input  logic [31:0]              rtc_sec_field,
    input  logic [15:0]              rtc_epoch_field,
    output logic                     ts_ret_vaild,
    output logic [79:0]              ts_ret_data,
    output logic [2:0]               ts_ret_id,
    output logic                     tx_timeout,
    output logic                     busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Last SEND count before the frame is abandoned.
    localparam logic [15:0] CNT_LIMIT = 16'(TX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RET  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_id_q, grant_id_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [79:0]        ret_data_q, ret_data_d;
    logic [2:0]         ret_id_q, ret_id_d;
    logic               tx_timeout_q, tx_timeout_d;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [FRAME_W-1:0] grant_frame;
    int                 best_dist;

    // Distance of source idx from the round-robin start point rr_ptr+1.
    // Distance 0 is the highest priority; the pointer itself is served last.
    function automatic int rr_dist(input int idx, input logic [PTR_W-1:0] ptr);
        return (idx - int'(ptr) - 1 + 2 * N_REQ) % N_REQ;
    endfunction

    // Round-robin search: choose the requesting source closest after rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        best_dist   = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_vaild[i] && (rr_dist(i, rr_ptr_q) < best_dist)) begin
                best_dist   = rr_dist(i, rr_ptr_q);
                grant_idx   = PTR_W'(i);
                grant_found = 1'b1;
            end
        end
    end

    // Mux out the frame of the winning source.
    always_comb begin
        grant_frame = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                grant_frame = req_data[i*FRAME_W +: FRAME_W];
            end
        end
    end

    // Accept is one-hot to the winner, only in IDLE, and suppressed while reset
    // is asserted because a grant on a reset edge would be discarded.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (state_q == ST_IDLE) && !reset && grant_found &&
                           (grant_idx == PTR_W'(i));
        end
    end

    // Next-state and datapath update for the IDLE -> SEND -> RET transfer cycle.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        cnt_d        = cnt_q;
        frame_d      = frame_q;
        ret_data_d   = ret_data_q;
        ret_id_d     = ret_id_q;
        tx_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    frame_d    = grant_frame;
                    grant_id_d = grant_idx;
                    rr_ptr_d   = grant_idx;
                    cnt_d      = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // A handshake in the limit cycle still counts: ready wins over timeout.
                if (gptp_ts_ready) begin
                    ret_data_d = {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field};
                    ret_id_d   = 3'(grant_id_q);
                    state_d    = ST_RET;
                end else if (cnt_q == CNT_LIMIT) begin
                    tx_timeout_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RET: begin
                // The timestamp return has no backpressure.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= PTR_W'(N_REQ - 1);
            grant_id_q   <= '0;
            cnt_q        <= '0;
            frame_q      <= '0;
            ret_data_q   <= '0;
            ret_id_q     <= '0;
            tx_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            ret_data_q   <= ret_data_d;
            ret_id_q     <= ret_id_d;
            tx_timeout_q <= tx_timeout_d;
        end
    end

    assign gptp_ts_vaild = (state_q == ST_SEND);
    assign gptp_ts_data  = frame_q;
    assign ts_ret_vaild  = (state_q == ST_RET);
    assign ts_ret_data   = ret_data_q;
    assign ts_ret_id     = ret_id_q;
    assign tx_timeout    = tx_timeout_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gptp_tx_arbiter.sv
// Testbench for gptp_tx_arbiter: directed segments plus randomized traffic.
// A transaction-level reference model runs over the whole stimulus plan up
// front and queues the expected grants, egress handshakes, timestamp returns
// and timeouts. A negedge monitor pops and compares them as the DUT shows them.
module tb_gptp_tx_arbiter;

    localparam int N    = 4;
    localparam int FW   = 352;
    localparam int TO   = 16;
    localparam int NCYC = 1600;
    localparam int NARR = NCYC + TO + 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_vaild;
    logic [N-1:0]    req_ready;
    logic [N*FW-1:0] req_data;
    logic            gptp_ts_vaild;
    logic            gptp_ts_ready;
    logic [FW-1:0]   gptp_ts_data;
    logic [31:0]     rtc_nanosec_field;
    logic [31:0]     rtc_sec_field;
    logic [15:0]     rtc_epoch_field;
    logic            ts_ret_vaild;
    logic [79:0]     ts_ret_data;
    logic [2:0]      ts_ret_id;
    logic            tx_timeout;
    logic            busy;

    always #5 clk = ~clk;

    gptp_tx_arbiter #(
        .N_REQ     (N),
        .FRAME_W   (FW),
        .TX_TIMEOUT(TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_vaild        (req_vaild),
        .req_ready        (req_ready),
        .req_data         (req_data),
        .gptp_ts_vaild    (gptp_ts_vaild),
        .gptp_ts_ready    (gptp_ts_ready),
        .gptp_ts_data     (gptp_ts_data),
        .rtc_nanosec_field(rtc_nanosec_field),
        .rtc_sec_field    (rtc_sec_field),
        .rtc_epoch_field  (rtc_epoch_field),
        .ts_ret_vaild     (ts_ret_vaild),
        .ts_ret_data      (ts_ret_data),
        .ts_ret_id        (ts_ret_id),
        .tx_timeout       (tx_timeout),
        .busy             (busy)
    );

    // Stimulus plan, one entry per cycle.
    logic [N-1:0] rv_a  [NARR];
    logic         rdy_a [NARR];
    logic         rst_a [NARR];
    logic [79:0]  rtc_a [NARR];

    typedef struct {
        int            cyc;
        int            id;
        logic [FW-1:0] frame;
    } frame_ev_t;

    typedef struct {
        int          cyc;
        int          id;
        logic [79:0] data;
    } ret_ev_t;

    frame_ev_t q_grant[$];
    frame_ev_t q_hs[$];
    ret_ev_t   q_ret[$];
    int        q_to[$];

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = -1;
    bit          done     = 1'b0;
    logic [31:0] seed;

    function automatic void chk(input bit ok, input string name, input string msg);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s cycle=%0d %s", name, cyc, msg);
        end
    endfunction

    // Each source offers a different frame in every cycle, so sampling at the
    // wrong edge or from the wrong source yields a different value.
    function automatic logic [FW-1:0] mkframe(input int c, input int s);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < FW / 32; k++) begin
            f[k*32 +: 32] = (32'(c) * 32'h9E3779B1) ^ (32'(s + 1) * 32'h85EBCA6B) ^
                            (32'(k) * 32'hC2B2AE35) ^ seed;
        end
        return f;
    endfunction

    task automatic build_stimulus();
        for (int c = 0; c < NARR; c++) begin
            rv_a[c]  = '0;
            rdy_a[c] = 1'b1;
            rst_a[c] = 1'b0;
            rtc_a[c] = {16'($urandom), 32'($urandom), 32'($urandom)};
        end
        for (int c = 0; c < 3; c++) rst_a[c] = 1'b1;
        // Single request with a known RTC value at the handshake.
        rv_a[3]  = 4'b0001;
        rtc_a[4] = 80'h0001_00000005_00000064;
        // All sources requesting, TX always ready.
        for (int c = 10; c <= 40; c++) rv_a[c] = 4'hF;
        // Source 2 stalls into a timeout while other requests toggle; source 3 keeps asking.
        rv_a[50] = 4'b0100;
        for (int c = 51; c <= 90; c++) rv_a[c] = 4'($urandom) | 4'b1000;
        for (int c = 50; c <= 69; c++) rdy_a[c] = 1'b0;
        // Ready arrives exactly in the last SEND cycle.
        rv_a[100] = 4'b0001;
        for (int c = 101; c <= 115; c++) rdy_a[c] = 1'b0;
        // Reset in the middle of SEND, then all sources request.
        rv_a[130] = 4'b0010;
        for (int c = 131; c <= 135; c++) begin
            rv_a[c]  = 4'($urandom);
            rdy_a[c] = 1'b0;
        end
        rst_a[135] = 1'b1;
        for (int c = 136; c <= 160; c++) rv_a[c] = 4'hF;
        // Reset while idle.
        rst_a[180] = 1'b1;
        // Random traffic with periodic ready droughts long enough to time out.
        for (int c = 200; c < NCYC - 60; c++) begin
            rv_a[c]  = 4'($urandom);
            rdy_a[c] = ($urandom_range(3, 0) != 0);
            if (((c / 100) % 3 == 0) && ((c % 100) < 30)) rdy_a[c] = 1'b0;
        end
    endtask

    // Transaction-level model: walk the plan frame by frame, computing grant
    // cycle, handshake or timeout cycle and return cycle from the arbitration
    // rules and latencies.
    task automatic build_model();
        int c;
        int ptr;
        int g;
        int d;
        bit fin;
        logic [FW-1:0] fr;
        c   = 0;
        ptr = N - 1;
        while (c < NCYC) begin
            if (rst_a[c]) begin
                ptr = N - 1;
                c++;
            end else if (rv_a[c] == '0) begin
                c++;
            end else begin
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && rv_a[c][(ptr + k) % N]) g = (ptr + k) % N;
                end
                ptr = g;
                fr  = mkframe(c, g);
                q_grant.push_back('{cyc: c, id: g, frame: fr});
                fin = 1'b0;
                for (int k = 1; k <= TO && !fin; k++) begin
                    d = c + k;
                    if (rst_a[d]) begin
                        ptr = N - 1;
                        c   = d + 1;
                        fin = 1'b1;
                    end else if (rdy_a[d]) begin
                        q_hs.push_back('{cyc: d, id: g, frame: fr});
                        q_ret.push_back('{cyc: d + 1, id: g, data: rtc_a[d]});
                        if (rst_a[d + 1]) ptr = N - 1;
                        c   = d + 2;
                        fin = 1'b1;
                    end
                end
                if (!fin) begin
                    q_to.push_back(c + TO + 1);
                    c = c + TO + 1;
                end
            end
        end
    endtask

    // Driver: applies the plan one cycle at a time, just after each rising edge.
    initial begin
        seed              = $urandom;
        reset             = 1'b1;
        req_vaild         = '0;
        req_data          = '0;
        gptp_ts_ready     = 1'b0;
        rtc_nanosec_field = '0;
        rtc_sec_field     = '0;
        rtc_epoch_field   = '0;
        build_stimulus();
        build_model();
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc           = c;
            reset         = rst_a[c];
            req_vaild     = rv_a[c];
            gptp_ts_ready = rdy_a[c];
            {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field} = rtc_a[c];
            for (int s = 0; s < N; s++) req_data[s*FW +: FW] = mkframe(c, s);
        end
        @(negedge clk);
        #1;
        done = 1'b1;
        chk(q_grant.size() == 0, "grants_pending", $sformatf("left=%0d want=0", q_grant.size()));
        chk(q_hs.size() == 0, "handshakes_pending", $sformatf("left=%0d want=0", q_hs.size()));
        chk(q_ret.size() == 0, "returns_pending", $sformatf("left=%0d want=0", q_ret.size()));
        chk(q_to.size() == 0, "timeouts_pending", $sformatf("left=%0d want=0", q_to.size()));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: samples DUT outputs mid-cycle and pops expectations as events appear.
    logic [FW-1:0] cur_frame = '0;
    frame_ev_t     ge;
    frame_ev_t     he;
    ret_ev_t       re;
    int            te;

    always @(negedge clk) begin
        if (!done && cyc >= 0) begin
            if (cyc > 0 && rst_a[cyc-1]) begin
                chk({gptp_ts_vaild, ts_ret_vaild, tx_timeout, busy} == 4'b0 &&
                    gptp_ts_data == '0 && ts_ret_data == '0 && ts_ret_id == 3'd0,
                    "reset_state",
                    $sformatf("got vld=%b ret=%b to=%b busy=%b id=%0d ret_data=%h want all zero",
                              gptp_ts_vaild, ts_ret_vaild, tx_timeout, busy, ts_ret_id, ts_ret_data));
            end
            if (req_ready != '0) begin
                if (q_grant.size() == 0) begin
                    chk(1'b0, "grant_unexpected", $sformatf("got req_ready=%b want 0000", req_ready));
                end else begin
                    ge = q_grant.pop_front();
                    chk(ge.cyc == cyc && req_ready == (4'b0001 << ge.id), "grant",
                        $sformatf("got req_ready=%b want %b at cycle %0d",
                                  req_ready, 4'b0001 << ge.id, ge.cyc));
                    cur_frame = ge.frame;
                end
            end
            if (gptp_ts_vaild) begin
                chk(gptp_ts_data == cur_frame, "frame_data",
                    $sformatf("got %h want %h", gptp_ts_data, cur_frame));
            end
            if (gptp_ts_vaild && gptp_ts_ready) begin
                if (q_hs.size() == 0) begin
                    chk(1'b0, "handshake_unexpected", "got egress handshake want none");
                end else begin
                    he = q_hs.pop_front();
                    chk(he.cyc == cyc && gptp_ts_data == he.frame, "handshake",
                        $sformatf("got data=%h want data=%h at cycle %0d",
                                  gptp_ts_data, he.frame, he.cyc));
                end
            end
            if (ts_ret_vaild) begin
                if (q_ret.size() == 0) begin
                    chk(1'b0, "ret_unexpected", $sformatf("got ts_ret id=%0d want none", ts_ret_id));
                end else begin
                    re = q_ret.pop_front();
                    chk(re.cyc == cyc && ts_ret_id == 3'(re.id) && ts_ret_data == re.data, "ts_ret",
                        $sformatf("got id=%0d data=%h want id=%0d data=%h at cycle %0d",
                                  ts_ret_id, ts_ret_data, re.id, re.data, re.cyc));
                end
            end
            if (tx_timeout) begin
                if (q_to.size() == 0) begin
                    chk(1'b0, "timeout_unexpected", "got tx_timeout want none");
                end else begin
                    te = q_to.pop_front();
                    chk(te == cyc, "timeout", $sformatf("got pulse at %0d want %0d", cyc, te));
                end
            end
            chk(busy == (gptp_ts_vaild || ts_ret_vaild), "busy",
                $sformatf("got busy=%b want %b", busy, gptp_ts_vaild || ts_ret_vaild));
        end
    end

endmodule
